// File: rtl/round_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : round_controller_pkg
//  Description : Shared definitions for the round sequencer. Holds the round
//                phase codes, player state codes, winner codes, default
//                tuning constants and small saturating arithmetic helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package round_controller_pkg;

    // Round phase, also driven out directly on the phase port
    typedef enum logic [2:0] {
        PHASE_IDLE      = 3'd0,
        PHASE_COUNTDOWN = 3'd1,
        PHASE_FIGHT     = 3'd2,
        PHASE_KO        = 3'd3,
        PHASE_MATCH_END = 3'd4
    } phase_e;

    // Player current_state codes as produced by the player instances
    typedef enum logic [3:0] {
        PST_IDLE      = 4'd0,
        PST_MOVE_FWD  = 4'd1,
        PST_MOVE_BACK = 4'd2,
        PST_ATK_START = 4'd3,
        PST_ATK_END   = 4'd4,
        PST_ATK_PULL  = 4'd5
    } player_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_e;

    localparam logic [6:0] c_max_health       = 7'd100;
    localparam logic [6:0] c_damage           = 7'd10;
    localparam logic [7:0] c_countdown_frames = 8'd180;
    localparam logic [7:0] c_ko_frames        = 8'd120;
    localparam logic [1:0] c_rounds_to_win    = 2'd2;

    // Health drops by the damage amount but never wraps below zero
    function automatic logic [6:0] sat_sub7(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : 7'd0;
    endfunction

    // Round counters stop at their maximum code
    function automatic logic [1:0] sat_inc2(input logic [1:0] a);
        return (a == 2'd3) ? 2'd3 : (a + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : round_controller_if
//  Description : Bundle between the frame/player side and the round
//                sequencer. The master side supplies frame tick, start,
//                player states and box corners; the slave (sequencer) drives
//                phase, enables, health, rounds, winner and hit pulses.
//  Ports       : none (signals listed below, grouped by modport)
//  Revision    : 1.0 - initial release
// ============================================================================
interface round_controller_if;

    logic       frame_tick;
    logic       start;
    logic [3:0] p1_state;
    logic [3:0] p2_state;

    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;

    logic       game_en;
    logic [2:0] phase;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] winner;
    logic       p1_hit_pulse;
    logic       p2_hit_pulse;

    modport master (
        output frame_tick, start, p1_state, p2_state,
        output p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
        output p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
        output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        input  game_en, phase, p1_health, p2_health,
        input  p1_rounds, p2_rounds, winner, p1_hit_pulse, p2_hit_pulse
    );

    modport slave (
        input  frame_tick, start, p1_state, p2_state,
        input  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
        input  p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
        input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        output game_en, phase, p1_health, p2_health,
        output p1_rounds, p2_rounds, winner, p1_hit_pulse, p2_hit_pulse
    );

endinterface
`default_nettype wire

// File: rtl/round_controller_box_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : box_overlap
//  Description : Combinational inclusive rectangle intersection test between
//                an attacker box (a) and a defender box (b). Coordinates are
//                unsigned; touching edges count as overlap.
//  Ports       : i_a_x1/x2/y1/y2 - attacker box corners
//                i_b_x1/x2/y1/y2 - defender box corners
//                o_overlap       - high when the two boxes share any pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module box_overlap (
    input  wire logic [9:0] i_a_x1,
    input  wire logic [9:0] i_a_x2,
    input  wire logic [9:0] i_a_y1,
    input  wire logic [9:0] i_a_y2,
    input  wire logic [9:0] i_b_x1,
    input  wire logic [9:0] i_b_x2,
    input  wire logic [9:0] i_b_y1,
    input  wire logic [9:0] i_b_y2,
    output logic            o_overlap
);

    logic w_x_overlap;
    logic w_y_overlap;

    always_comb begin
        w_x_overlap = (i_a_x1 <= i_b_x2) && (i_b_x1 <= i_a_x2);
        w_y_overlap = (i_a_y1 <= i_b_y2) && (i_b_y1 <= i_a_y2);
        o_overlap   = w_x_overlap && w_y_overlap;
    end

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : round_controller
//  Description : Match/round sequencer between the frame tick and the two
//                players. Gates player movement, resolves hitbox vs hurtbox
//                contacts once per frame, applies damage, counts round wins
//                and steps the phase IDLE -> COUNTDOWN -> FIGHT -> KO ->
//                (COUNTDOWN | MATCH_END). All outputs are registered.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - round_controller_if.slave: frame_tick, start, player
//                       states and box corners in; game_en, phase, health,
//                       rounds, winner and hit pulses out
//  Revision    : 1.0 - initial release
// ============================================================================
module round_controller
    import round_controller_pkg::*;
#(
    parameter logic [6:0] MAX_HEALTH       = c_max_health,
    parameter logic [6:0] DAMAGE           = c_damage,
    parameter logic [7:0] COUNTDOWN_FRAMES = c_countdown_frames,
    parameter logic [7:0] KO_FRAMES        = c_ko_frames,
    parameter logic [1:0] ROUNDS_TO_WIN    = c_rounds_to_win,
    parameter logic [3:0] ACTIVE_STATE     = PST_ATK_END
) (
    input  wire logic          clk,
    input  wire logic          rst,
    round_controller_if.slave  bus
);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    phase_e     r_phase_q,        w_phase_d;
    logic [7:0] r_frame_cnt_q,    w_frame_cnt_d;
    logic [6:0] r_p1_health_q,    w_p1_health_d;
    logic [6:0] r_p2_health_q,    w_p2_health_d;
    logic [1:0] r_p1_rounds_q,    w_p1_rounds_d;
    logic [1:0] r_p2_rounds_q,    w_p2_rounds_d;
    logic [1:0] r_winner_q,       w_winner_d;
    logic       r_hit_done1_q,    w_hit_done1_d;
    logic       r_hit_done2_q,    w_hit_done2_d;
    logic       r_p1_hit_pulse_q, w_p1_hit_pulse_d;
    logic       r_p2_hit_pulse_q, w_p2_hit_pulse_d;
    logic       r_game_en_q,      w_game_en_d;

    // ------------------------------------------------------------------
    // Hit detection
    // ------------------------------------------------------------------
    logic w_ovl_p1_on_p2;   // P1 hitbox touches P2 hurtbox
    logic w_ovl_p2_on_p1;   // P2 hitbox touches P1 hurtbox
    logic w_p1_active;
    logic w_p2_active;
    logic w_hit1;           // P1 lands on P2 this tick
    logic w_hit2;           // P2 lands on P1 this tick

    box_overlap u_ovl_p1_on_p2 (
        .i_a_x1    (bus.p1_hit_x1),
        .i_a_x2    (bus.p1_hit_x2),
        .i_a_y1    (bus.p1_hit_y1),
        .i_a_y2    (bus.p1_hit_y2),
        .i_b_x1    (bus.p2_hurt_x1),
        .i_b_x2    (bus.p2_hurt_x2),
        .i_b_y1    (bus.p2_hurt_y1),
        .i_b_y2    (bus.p2_hurt_y2),
        .o_overlap (w_ovl_p1_on_p2)
    );

    box_overlap u_ovl_p2_on_p1 (
        .i_a_x1    (bus.p2_hit_x1),
        .i_a_x2    (bus.p2_hit_x2),
        .i_a_y1    (bus.p2_hit_y1),
        .i_a_y2    (bus.p2_hit_y2),
        .i_b_x1    (bus.p1_hurt_x1),
        .i_b_x2    (bus.p1_hurt_x2),
        .i_b_y1    (bus.p1_hurt_y1),
        .i_b_y2    (bus.p1_hurt_y2),
        .o_overlap (w_ovl_p2_on_p1)
    );

    always_comb begin
        w_p1_active = (bus.p1_state == ACTIVE_STATE);
        w_p2_active = (bus.p2_state == ACTIVE_STATE);
        // hit_done blocks a held attack frame from landing on every tick
        w_hit1      = w_p1_active && !r_hit_done1_q && w_ovl_p1_on_p2;
        w_hit2      = w_p2_active && !r_hit_done2_q && w_ovl_p2_on_p1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_d        = r_phase_q;
        w_frame_cnt_d    = r_frame_cnt_q;
        w_p1_health_d    = r_p1_health_q;
        w_p2_health_d    = r_p2_health_q;
        w_p1_rounds_d    = r_p1_rounds_q;
        w_p2_rounds_d    = r_p2_rounds_q;
        w_winner_d       = r_winner_q;
        w_hit_done1_d    = r_hit_done1_q;
        w_hit_done2_d    = r_hit_done2_q;
        w_p1_hit_pulse_d = 1'b0;
        w_p2_hit_pulse_d = 1'b0;

        case (r_phase_q)
            PHASE_IDLE: begin
                // start is a level and does not wait for a frame tick
                if (bus.start) begin
                    w_phase_d     = PHASE_COUNTDOWN;
                    w_frame_cnt_d = 8'd0;
                    w_p1_health_d = MAX_HEALTH;
                    w_p2_health_d = MAX_HEALTH;
                    w_hit_done1_d = 1'b0;
                    w_hit_done2_d = 1'b0;
                end
            end

            PHASE_COUNTDOWN: begin
                if (bus.frame_tick) begin
                    if (r_frame_cnt_q == COUNTDOWN_FRAMES - 8'd1) begin
                        w_phase_d     = PHASE_FIGHT;
                        w_frame_cnt_d = 8'd0;
                    end else begin
                        w_frame_cnt_d = r_frame_cnt_q + 8'd1;
                    end
                end
            end

            PHASE_FIGHT: begin
                if (bus.frame_tick) begin
                    // Re-arm once the attacker leaves the active frame
                    w_hit_done1_d = w_p1_active && (r_hit_done1_q || w_hit1);
                    w_hit_done2_d = w_p2_active && (r_hit_done2_q || w_hit2);

                    if (w_hit1) begin
                        w_p2_health_d    = sat_sub7(r_p2_health_q, DAMAGE);
                        w_p2_hit_pulse_d = 1'b1;
                    end
                    if (w_hit2) begin
                        w_p1_health_d    = sat_sub7(r_p1_health_q, DAMAGE);
                        w_p1_hit_pulse_d = 1'b1;
                    end

                    // KO is judged on post-damage health; a double KO is a
                    // draw and awards nobody
                    if ((w_p1_health_d == 7'd0) || (w_p2_health_d == 7'd0)) begin
                        w_phase_d     = PHASE_KO;
                        w_frame_cnt_d = 8'd0;
                        if ((w_p2_health_d == 7'd0) && (w_p1_health_d != 7'd0)) begin
                            w_p1_rounds_d = sat_inc2(r_p1_rounds_q);
                        end
                        if ((w_p1_health_d == 7'd0) && (w_p2_health_d != 7'd0)) begin
                            w_p2_rounds_d = sat_inc2(r_p2_rounds_q);
                        end
                    end
                end
            end

            PHASE_KO: begin
                if (bus.frame_tick) begin
                    if (r_frame_cnt_q == KO_FRAMES - 8'd1) begin
                        w_frame_cnt_d = 8'd0;
                        if ((r_p1_rounds_q == ROUNDS_TO_WIN) ||
                            (r_p2_rounds_q == ROUNDS_TO_WIN)) begin
                            w_phase_d  = PHASE_MATCH_END;
                            w_winner_d = (r_p1_rounds_q == ROUNDS_TO_WIN) ? WIN_P1 : WIN_P2;
                        end else begin
                            w_phase_d     = PHASE_COUNTDOWN;
                            w_p1_health_d = MAX_HEALTH;
                            w_p2_health_d = MAX_HEALTH;
                            w_hit_done1_d = 1'b0;
                            w_hit_done2_d = 1'b0;
                        end
                    end else begin
                        w_frame_cnt_d = r_frame_cnt_q + 8'd1;
                    end
                end
            end

            PHASE_MATCH_END: begin
                if (bus.start) begin
                    w_phase_d     = PHASE_COUNTDOWN;
                    w_frame_cnt_d = 8'd0;
                    w_p1_health_d = MAX_HEALTH;
                    w_p2_health_d = MAX_HEALTH;
                    w_p1_rounds_d = 2'd0;
                    w_p2_rounds_d = 2'd0;
                    w_winner_d    = WIN_NONE;
                    w_hit_done1_d = 1'b0;
                    w_hit_done2_d = 1'b0;
                end
            end

            default: begin
                w_phase_d = PHASE_IDLE;
            end
        endcase

        // Enable follows the phase being entered so it lines up with phase
        w_game_en_d = (w_phase_d == PHASE_FIGHT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_q        <= PHASE_IDLE;
            r_frame_cnt_q    <= 8'd0;
            r_p1_health_q    <= MAX_HEALTH;
            r_p2_health_q    <= MAX_HEALTH;
            r_p1_rounds_q    <= 2'd0;
            r_p2_rounds_q    <= 2'd0;
            r_winner_q       <= WIN_NONE;
            r_hit_done1_q    <= 1'b0;
            r_hit_done2_q    <= 1'b0;
            r_p1_hit_pulse_q <= 1'b0;
            r_p2_hit_pulse_q <= 1'b0;
            r_game_en_q      <= 1'b0;
        end else begin
            r_phase_q        <= w_phase_d;
            r_frame_cnt_q    <= w_frame_cnt_d;
            r_p1_health_q    <= w_p1_health_d;
            r_p2_health_q    <= w_p2_health_d;
            r_p1_rounds_q    <= w_p1_rounds_d;
            r_p2_rounds_q    <= w_p2_rounds_d;
            r_winner_q       <= w_winner_d;
            r_hit_done1_q    <= w_hit_done1_d;
            r_hit_done2_q    <= w_hit_done2_d;
            r_p1_hit_pulse_q <= w_p1_hit_pulse_d;
            r_p2_hit_pulse_q <= w_p2_hit_pulse_d;
            r_game_en_q      <= w_game_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.game_en      = r_game_en_q;
    assign bus.phase        = r_phase_q;
    assign bus.p1_health    = r_p1_health_q;
    assign bus.p2_health    = r_p2_health_q;
    assign bus.p1_rounds    = r_p1_rounds_q;
    assign bus.p2_rounds    = r_p2_rounds_q;
    assign bus.winner       = r_winner_q;
    assign bus.p1_hit_pulse = r_p1_hit_pulse_q;
    assign bus.p2_hit_pulse = r_p2_hit_pulse_q;

endmodule
`default_nettype wire

// File: doc/round_controller.md
Name: round_controller

Overview:
- Match/round sequencer that sits between the frame tick and the two `player` instances.
- Each frame it gates player movement (`game_en`), tests attacker hitboxes against opponent hurtboxes, and applies damage.
- It tracks health and round wins and drives the round phase through countdown, fight, KO and match end.
- Its outputs feed the HUD/colour mux and the player enables.

Parameters:
- MAX_HEALTH, 7'd100: health loaded at round start.
- DAMAGE, 7'd10: health removed per registered hit.
- COUNTDOWN_FRAMES, 8'd180: frames spent in COUNTDOWN before FIGHT.
- KO_FRAMES, 8'd120: frames spent in KO before the next round or match end.
- ROUNDS_TO_WIN, 2'd2: round wins that end the match.
- ACTIVE_STATE, 4'd4: player `current_state` code (attack end) in which the hitbox is live.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (end of line 479)
- start  in  1  level; begins a match
- p1_state, p2_state  in  4 each  player current_state
- p1_hit_x1/x2/y1/y2, p2_hit_x1/x2/y1/y2  in  10 each  basic hithurtbox corners (inclusive)
- p1_hurt_x1/x2/y1/y2, p2_hurt_x1/x2/y1/y2  in  10 each  main hurtbox corners (inclusive)
- game_en  out  1  players may update (FIGHT only)
- phase  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_END=4
- p1_health, p2_health  out  7 each
- p1_rounds, p2_rounds  out  2 each
- winner  out  2  0 none, 1 P1, 2 P2
- p1_hit_pulse, p2_hit_pulse  out  1 each  one-cycle pulse when that player takes damage

Behaviour:
- Reset state, taking effect at the next clk edge whenever rst is high, including mid-round:
  - phase=IDLE, game_en=0.
  - p1_health = p2_health = MAX_HEALTH.
  - p1_rounds = p2_rounds = 0, winner=0, hit pulses=0.
  - Frame counter 0, hit_done flags 0.
- All outputs are registered. Frame-driven work happens only on cycles with frame_tick=1; results are visible one clk later.
- IDLE:
  - start=1 enters COUNTDOWN (no frame_tick needed), reloads both healths and clears the frame counter.
  - start in any other phase except MATCH_END is ignored.
- COUNTDOWN:
  - Counter increments per frame_tick.
  - When the counter reaches COUNTDOWN_FRAMES-1 on a tick: enter FIGHT, clear the counter.
- FIGHT:
  - game_en=1 throughout.
  - Each tick computes hit1 = (p1_state==ACTIVE_STATE) && !hit_done1 && overlap(p1_hit, p2_hurt); hit2 is the symmetric case.
  - overlap(a,b) = a.x1<=b.x2 && b.x1<=a.x2 && a.y1<=b.y2 && b.y1<=a.y2, unsigned, inclusive.
  - hit1 sets hit_done1, reduces p2_health by DAMAGE (saturating at 0) and pulses p2_hit_pulse; hit2 is symmetric.
  - hit_done_n clears on any tick where p_n state != ACTIVE_STATE, so one attack lands at most once.
  - Simultaneous hits on one tick: both apply.
- KO detection, in the same update as the damage:
  - If either health becomes 0: enter KO, game_en=0 at the next edge, counter cleared.
  - Only P2 at 0: p1_rounds += 1.
  - Only P1 at 0: p2_rounds += 1.
  - Both at 0: draw, no round awarded.
- KO:
  - After KO_FRAMES ticks: if either rounds count == ROUNDS_TO_WIN, enter MATCH_END and set winner.
  - Otherwise reload healths, clear hit_done, enter COUNTDOWN.
- MATCH_END:
  - Outputs hold.
  - start=1 clears rounds and winner, reloads healths and enters COUNTDOWN.
- Widths:
  - Rounds counters saturate at 3.
  - DAMAGE>MAX_HEALTH is legal (a single hit gives KO).
- Hitboxes are sampled only on the tick; inputs between ticks are don't-care.

Decomposition:
- Shared include `demoman_defs`:
  - phase encodings.
  - Player state codes (IDLE 0, MOVE_FWD 1, MOVE_BACK 2, ATK_START 3, ATK_END 4, ATK_PULL 5).
  - winner codes.
- Sub-module `box_overlap`: purely combinational inclusive rectangle test, instantiated twice (P1→P2, P2→P1).

Test Plan:
- Start and countdown: rst, then start=1 for 1 cycle, then 180 ticks → phase 0→1, then 2 one cycle after tick 180; game_en=1; healths 100/100.
- Single hit, no repeat: FIGHT, p1_state=4, P1 hitbox (200,100)-(260,140) overlapping P2 hurtbox (250,90)-(350,250), held for 5 ticks → p2_health=90 after the first tick only, one p2_hit_pulse. Then p1_state=5 for 1 tick and back to 4 → p2_health=80.
- Non-overlap edge: P1 hit x2=249, P2 hurt x1=250, state 4 → no damage. Then x2=250 → damage (inclusive bound).
- Simultaneous KO (draw): both healths 10, mutual overlapping hits on the same tick → both 0, phase=KO, rounds 0/0. After 120 ticks → COUNTDOWN, healths 100.
- Match win: P1 KOs P2 twice → p1_rounds=2, phase=MATCH_END, winner=1, game_en=0. Then start → rounds 0/0, winner 0, phase=COUNTDOWN.
- Reset mid-FIGHT: rst high for 1 cycle with p2_health=40, p1_rounds=1 → next edge phase=IDLE, healths 100, rounds 0, game_en=0.
